prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program loader; the producer end of the CPU's observation path.
- Receives a framed byte stream from a UART RX and writes 32-bit words into the CPU instruction memory.
- Holds the CPU core in reset until a frame loads with a correct checksum, then releases it to run.
- Sits between the UART RX and the instruction-memory write port / System_topEntity reset input.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- DEPTH, 1024, maximum loadable words; must satisfy DEPTH <= 2**ADDR_W.
- TIMEOUT, 100000, maximum idle cycles between bytes inside a frame.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte; no backpressure.
- rx_data  in  8  received byte.
- rx_err  in  1  one-cycle strobe: UART framing error.
- mem_we  out  1  instruction-memory write enable, one-cycle pulse.
- mem_addr  out  ADDR_W  word address of the write.
- mem_wdata  out  32  word to write.
- cpu_reset  out  1  active-high reset to the CPU core.
- load_busy  out  1  frame in progress.
- load_done  out  1  last frame loaded OK (sticky).
- load_error  out  1  last frame failed (sticky).
- err_code  out  2  failure cause: 0 none, 1 checksum, 2 length, 3 timeout/rx_err.

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, load_busy=0, load_done=0, load_error=0, err_code=0, state=IDLE.
- Frame format: SYNC_BYTE; N_lo; N_hi (16-bit word count); N x 4 data bytes, little-endian per word; CSUM.
- CSUM is the XOR of all data bytes. With N=0, CSUM=8'h00.
- IDLE: rx_valid && rx_data==SYNC_BYTE -> LEN0. Set cpu_reset=1, load_busy=1, clear done/error/err_code, reset word index and running XOR. Other bytes are ignored.
- LEN0: capture N_lo -> LEN1.
- LEN1: capture N_hi. Then:
  - N > DEPTH -> ERR, code 2.
  - N == 0 -> CSUM.
  - otherwise -> DATA.
- DATA:
  - Shift each byte into the word assembler and XOR it into the running checksum.
  - On the 4th byte, in the next cycle: mem_we=1, mem_addr=word index, mem_wdata=assembled word. The index then increments; a write completes one cycle after its last byte.
  - After word N-1 -> CSUM.
  - Byte order: first byte is bits [7:0].
- CSUM: byte == running XOR -> DONE, else ERR code 1.
- DONE: load_done=1, load_busy=0, cpu_reset=0 (deasserts the cycle after the checksum byte).
- ERR: load_error=1, load_busy=0, cpu_reset stays 1, err_code held.
- Restart: from both DONE and ERR, a SYNC_BYTE starts a new frame exactly as from IDLE (cpu_reset reasserts the next cycle). Other bytes are ignored.
- Timeout: in LEN0/LEN1/DATA/CSUM the idle counter resets on each rx_valid. Reaching TIMEOUT -> ERR, code 3.
- rx_err in any in-frame state -> ERR, code 3. rx_err is ignored in IDLE/DONE/ERR.
- Simultaneous rx_valid and rx_err: rx_err wins; the byte is discarded.
- A SYNC_BYTE value inside a frame is treated as data, never as a resync.
- Address wrap is impossible: N <= DEPTH is enforced.
- Reset mid-frame: all state cleared asynchronously; no further mem_we; cpu_reset=1.
- mem_we is never asserted outside DATA and its following cycle.

Decomposition:
- Shared include/package holds:
  - state encoding: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR;
  - err_code constants: ERR_NONE, ERR_CSUM, ERR_LEN, ERR_TIMEOUT;
  - default SYNC_BYTE.
- One sub-module, prog_loader_word_asm: byte-to-32-bit assembler.
  - Inputs: byte strobe, byte, clear.
  - Outputs: word, word_valid pulse, 2-bit byte counter.
- FSM, word index, checksum and timeout counter stay in prog_loader.

Test Plan:
- Good frame A5 02 00 | 13 00 00 00 | 93 00 10 00 | CSUM=0x90 -> writes (0, 0x00000013), then (1, 0x00100093); load_done=1; cpu_reset falls the cycle after the CSUM byte.
- Same frame with CSUM=0x91 -> both writes occur; load_error=1, err_code=1, cpu_reset stays 1.
- A5 01 04 (N=1025 > DEPTH) -> ERR code 2 after LEN1; no mem_we; later bytes ignored until the next A5.
- Good frame with TIMEOUT idle cycles after its 5th data byte -> ERR code 3; exactly one write (word 0); cpu_reset=1.
- rx_err pulsed together with a data byte -> ERR code 3; that byte is not written. A subsequent good N=0 frame (A5 00 00 00) -> load_done=1, err_code=0, cpu_reset=0.
- Async reset asserted between the 2nd and 3rd word of N=4 -> outputs return to reset values immediately; no further writes; re-sent frame loads all 4 words from address 0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the FSM state encoding, the failure-cause codes and the default frame marker.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_e;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'd0;
  localparam err_code_t ERR_CSUM    = 2'd1;
  localparam err_code_t ERR_LEN     = 2'd2;
  localparam err_code_t ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // States in which a frame is being received; rx_err and the idle timer only apply here.
  function automatic logic in_frame(input state_e s);
    return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_word_asm.sv
// Little-endian byte-to-word assembler: the first byte of a word lands in bits [7:0].
// word_valid_o pulses the cycle after the fourth byte, while word_o holds the complete word.
module prog_loader_word_asm (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic [1:0]  byte_cnt_o
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else if (byte_valid_i) begin
      // Shifting in from the top leaves the first byte at [7:0] after four strobes.
      shift_d = {byte_i, shift_q[31:8]};
      cnt_d   = cnt_q + 2'd1;
      valid_d = (cnt_q == 2'd3);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= 32'd0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign word_o       = shift_q;
  assign word_valid_o = valid_q;
  assign byte_cnt_o   = cnt_q;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses SYNC/length/data/checksum frames from a UART RX, writes words into
// instruction memory and holds the CPU in reset until a frame loads with a good checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter int         DEPTH     = 1024,
  parameter int         TIMEOUT   = 100000,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_error,
  output logic [1:0]        err_code
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  err_code_t       err_code_q, err_code_d;
  logic [7:0]      len_lo_q, len_lo_d;
  logic [15:0]     n_words_q, n_words_d;
  logic [15:0]     word_idx_q, word_idx_d;
  logic [7:0]      csum_q, csum_d;
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;

  logic            asm_strobe;
  logic            asm_clear;
  logic [31:0]     asm_word;
  logic            asm_word_valid;
  logic [1:0]      asm_byte_cnt;

  logic            fail;
  err_code_t       fail_code;
  logic [15:0]     n_rx;

  assign n_rx = {rx_data, len_lo_q};

  prog_loader_word_asm u_word_asm (
    .clk          (clk),
    .rst_ni       (reset),
    .byte_valid_i (asm_strobe),
    .byte_i       (rx_data),
    .clear_i      (asm_clear),
    .word_o       (asm_word),
    .word_valid_o (asm_word_valid),
    .byte_cnt_o   (asm_byte_cnt)
  );

  always_comb begin
    state_d     = state_q;
    cpu_reset_d = cpu_reset_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    len_lo_d    = len_lo_q;
    n_words_d   = n_words_q;
    word_idx_d  = word_idx_q;
    csum_d      = csum_q;
    idle_cnt_d  = idle_cnt_q;
    asm_strobe  = 1'b0;
    asm_clear   = 1'b0;
    fail        = 1'b0;
    fail_code   = ERR_NONE;

    // The index advances in the cycle its word is being written, so mem_addr tracks it.
    if (asm_word_valid) begin
      word_idx_d = word_idx_q + 16'd1;
    end

    if (!in_frame(state_q)) begin
      if (rx_valid && (rx_data == SYNC_BYTE)) begin
        state_d     = LEN0;
        cpu_reset_d = 1'b1;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        error_d     = 1'b0;
        err_code_d  = ERR_NONE;
        word_idx_d  = 16'd0;
        csum_d      = 8'd0;
        idle_cnt_d  = '0;
        asm_clear   = 1'b1;
      end
    end else if (rx_err) begin
      fail      = 1'b1;
      fail_code = ERR_TIMEOUT;
    end else if (rx_valid) begin
      idle_cnt_d = '0;
      unique case (state_q)
        LEN0: begin
          len_lo_d = rx_data;
          state_d  = LEN1;
        end
        LEN1: begin
          n_words_d = n_rx;
          if (n_rx > 16'(DEPTH)) begin
            fail      = 1'b1;
            fail_code = ERR_LEN;
          end else if (n_rx == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          asm_strobe = 1'b1;
          csum_d     = csum_q ^ rx_data;
          if ((asm_byte_cnt == 2'd3) && (word_idx_q == n_words_q - 16'd1)) begin
            state_d = CSUM;
          end
        end
        CSUM: begin
          if (rx_data == csum_q) begin
            state_d     = DONE;
            cpu_reset_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_CSUM;
          end
        end
        default: ;
      endcase
    end else if (idle_cnt_q == TO_LAST) begin
      fail      = 1'b1;
      fail_code = ERR_TIMEOUT;
    end else begin
      idle_cnt_d = idle_cnt_q + TO_W'(1);
    end

    if (fail) begin
      state_d     = ERR;
      cpu_reset_d = 1'b1;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      error_d     = 1'b1;
      err_code_d  = fail_code;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
      len_lo_q    <= 8'd0;
      n_words_q   <= 16'd0;
      word_idx_q  <= 16'd0;
      csum_q      <= 8'd0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      len_lo_q    <= len_lo_d;
      n_words_q   <= n_words_d;
      word_idx_q  <= word_idx_d;
      csum_q      <= csum_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

  assign mem_we     = asm_word_valid;
  assign mem_addr   = word_idx_q[ADDR_W-1:0];
  assign mem_wdata  = asm_word;
  assign cpu_reset  = cpu_reset_q;
  assign load_busy  = busy_q;
  assign load_done  = done_q;
  assign load_error = error_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected memory writes go into a scoreboard queue and a
// negedge monitor pops and compares them; status outputs are checked after each frame.
module tb_prog_loader;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_err = 1'b0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        load_busy;
  logic        load_done;
  logic        load_error;
  logic [1:0]  err_code;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  failures = 0;

  prog_loader #(
    .ADDR_W (10),
    .DEPTH  (1024),
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_err    (rx_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .load_busy (load_busy),
    .load_done (load_done),
    .load_error(load_error),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every mem_we must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=addr %0d data 0x%08h required=no write",
                 mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        $display("write addr=%0d data=0x%08h (expected addr=%0d data=0x%08h)",
                 mem_addr, mem_wdata, mon_e.a, mon_e.d);
        chk("write_addr", 32'(mem_addr), 32'(mon_e.a));
        chk("write_data", mem_wdata, mon_e.d);
      end
    end
  end

  task automatic push_wr(input logic [9:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic err = 1'b0);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_err   = err;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bs[$]);
    foreach (bs[i]) send(bs[i]);
  endtask

  // Checksum byte with the cpu_reset release/hold checked on both sides of the sampling edge.
  task automatic send_csum(input logic [7:0] b, input logic expect_release, input string tag);
    rx_valid = 1'b1;
    rx_data  = b;
    chk({tag, "_cpu_reset_before_csum"}, 32'(cpu_reset), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk({tag, "_cpu_reset_after_csum"}, 32'(cpu_reset), expect_release ? 32'd0 : 32'd1);
  endtask

  task automatic drained(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic status(input string tag, input logic done, input logic err,
                        input logic [1:0] code, input logic cpu_rst);
    chk({tag, "_load_done"}, 32'(load_done), 32'(done));
    chk({tag, "_load_error"}, 32'(load_error), 32'(err));
    chk({tag, "_err_code"}, 32'(err_code), 32'(code));
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(cpu_rst));
    chk({tag, "_load_busy"}, 32'(load_busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    status("rst", 1'b0, 1'b0, 2'd0, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Good two-word frame
    send(8'hA5);
    chk("t1_busy_after_sync", 32'(load_busy), 32'd1);
    push_wr(10'd0, 32'h0000_0013);
    push_wr(10'd1, 32'h0010_0093);
    send_bytes('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00});
    send_csum(8'h90, 1'b1, "t1");
    drained("t1");
    status("t1", 1'b1, 1'b0, 2'd0, 1'b0);

    // Same frame, bad checksum
    send(8'hA5);
    chk("t2_cpu_reset_reassert", 32'(cpu_reset), 32'd1);
    chk("t2_done_cleared", 32'(load_done), 32'd0);
    push_wr(10'd0, 32'h0000_0013);
    push_wr(10'd1, 32'h0010_0093);
    send_bytes('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00});
    send_csum(8'h91, 1'b0, "t2");
    drained("t2");
    status("t2", 1'b0, 1'b1, 2'd1, 1'b1);

    // Length too large (1025); trailing bytes ignored
    send_bytes('{8'hA5, 8'h01, 8'h04});
    status("t3", 1'b0, 1'b1, 2'd2, 1'b1);
    send_bytes('{8'h13, 8'h00, 8'h00, 8'h00, 8'h90});
    drained("t3");
    status("t3_after", 1'b0, 1'b1, 2'd2, 1'b1);

    // Timeout after the fifth data byte; only word 0 is written
    push_wr(10'd0, 32'h0000_0013);
    send_bytes('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93});
    repeat (TO - 2) @(posedge clk);
    #1;
    chk("t4_busy_before_timeout", 32'(load_busy), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    drained("t4");
    status("t4", 1'b0, 1'b1, 2'd3, 1'b1);

    // rx_err together with a data byte, then a good empty frame
    send_bytes('{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00});
    send(8'h00, 1'b1);
    send_bytes('{8'h00, 8'h00});
    drained("t5");
    status("t5", 1'b0, 1'b1, 2'd3, 1'b1);
    send_bytes('{8'hA5, 8'h00, 8'h00});
    send_csum(8'h00, 1'b1, "t5b");
    status("t5b", 1'b1, 1'b0, 2'd0, 1'b0);

    // Async reset between word 1 and word 2 of a four-word frame
    push_wr(10'd0, 32'h1122_3344);
    push_wr(10'd1, 32'hA5A5_A5A5);
    send_bytes('{8'hA5, 8'h04, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hEF, 8'hBE});
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_rst_mem_we", 32'(mem_we), 32'd0);
    chk("t6_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("t6_rst_mem_wdata", mem_wdata, 32'd0);
    chk("t6_rst_pending", 32'(exp_q.size()), 32'd0);
    status("t6_rst", 1'b0, 1'b0, 2'd0, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    send_bytes('{8'hAD, 8'hDE, 8'h01, 8'h00, 8'h00, 8'h00, 8'h67});
    drained("t6_idle");
    status("t6_idle", 1'b0, 1'b0, 2'd0, 1'b1);
    push_wr(10'd0, 32'h1122_3344);
    push_wr(10'd1, 32'hA5A5_A5A5);
    push_wr(10'd2, 32'hDEAD_BEEF);
    push_wr(10'd3, 32'h0000_0001);
    send_bytes('{8'hA5, 8'h04, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                 8'h01, 8'h00, 8'h00, 8'h00});
    send_csum(8'h67, 1'b1, "t6");
    drained("t6");
    status("t6", 1'b1, 1'b0, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
